// File: rtl/memory_stage_ctrl_if.sv
// Data-memory request/response bundle between the memory-stage controller
// (master) and the data memory (slave).
//
// Handshake: a request is offered while mem_en=1 and is accepted on the
// rising edge where mem_en=1 and mem_stall=0. While mem_stall=1 the master
// holds mem_en, mem_wr, mem_addr and mem_wdata unchanged. After acceptance
// the memory pulses mem_done for exactly one cycle, with mem_rdata valid in
// that same cycle. Only one access is outstanding at any time.
interface memory_stage_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  mem_en;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_stall;
  logic                  mem_done;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_en,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_stall,
    input  mem_done,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_stall,
    output mem_done,
    output mem_rdata
  );
endinterface

// File: rtl/memory_stage_ctrl.sv
// Memory-stage controller of the 5-stage pipeline.
// Reads the EX/MEM latch and issues at most one data-memory access at a time.
// While an access is outstanding it raises stall_m so that EX/MEM and every
// earlier stage stay frozen. Results go to WB through the internal MEM/WB
// register, which holds a bubble (valid_w=0) while the pipe is stalled.
// An access is aborted with err_w=1 when it stays in WAIT for
// TIMEOUT_CYCLES cycles.
// Optional build macro MEM_STALL_CNT_EN adds the output stallCycles. It is a
// 16-bit saturating count of the cycles with stall_m=1.
module memory_stage_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_m,
  input  logic                  memRead_m,
  input  logic                  memWrite_m,
  input  logic                  memToReg_m,
  input  logic                  halt_m,
  input  logic [DATA_WIDTH-1:0] aluOut_m,
  input  logic [DATA_WIDTH-1:0] read2Data_m,
  memory_stage_ctrl_if.master   mem,
  output logic                  stall_m,
  output logic                  valid_w,
  output logic [DATA_WIDTH-1:0] aluOut_w,
  output logic [DATA_WIDTH-1:0] readData_w,
  output logic                  memToReg_w,
  output logic                  halt_w,
  output logic                  err_w,
  output logic [1:0]            state_dbg
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [15:0]           stallCycles
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Controller state and captured request
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_wr_q, req_wr_d;
  logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
  logic                  req_m2r_q, req_m2r_d;

  // MEM/WB register
  logic                  valid_w_q, valid_w_d;
  logic [DATA_WIDTH-1:0] alu_w_q, alu_w_d;
  logic [DATA_WIDTH-1:0] rdata_w_q, rdata_w_d;
  logic                  m2r_w_q, m2r_w_d;
  logic                  halt_w_q, halt_w_d;
  logic                  err_w_q, err_w_d;

`ifdef MEM_STALL_CNT_EN
  logic [15:0]           stall_cnt_q, stall_cnt_d;
`endif

  // Combinational request and stall, before reset gating
  logic                  mem_en_c;
  logic                  mem_wr_c;
  logic [DATA_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic                  stall_c;

  logic                  memop;
  logic                  misaligned;

  // Classify the instruction in EX/MEM: a legal access, or an odd-address access
  assign memop      = valid_m & (memRead_m | memWrite_m) & ~halt_m & ~aluOut_m[0];
  assign misaligned = valid_m & (memRead_m | memWrite_m) & aluOut_m[0];

  // Next-state, request and MEM/WB load logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_m2r_d   = req_m2r_q;

    // MEM/WB defaults to a bubble; the data fields keep their old value
    valid_w_d   = 1'b0;
    err_w_d     = 1'b0;
    halt_w_d    = 1'b0;
    alu_w_d     = alu_w_q;
    rdata_w_d   = rdata_w_q;
    m2r_w_d     = m2r_w_q;

    mem_en_c    = 1'b0;
    mem_wr_c    = req_wr_q;
    mem_addr_c  = req_addr_q;
    mem_wdata_c = req_wdata_q;
    stall_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (memop) begin
          // Offer the request straight from EX/MEM in the same cycle
          mem_en_c    = 1'b1;
          mem_wr_c    = memWrite_m;
          mem_addr_c  = aluOut_m;
          mem_wdata_c = read2Data_m;
          stall_c     = 1'b1;
          req_wr_d    = memWrite_m;
          req_addr_d  = aluOut_m;
          req_wdata_d = read2Data_m;
          req_m2r_d   = memToReg_m;
          cnt_d       = '0;
          state_d     = mem.mem_stall ? S_REQ : S_WAIT;
        end else begin
          // Non-memory, halt, misaligned or empty slot: pass through in one cycle
          valid_w_d = valid_m;
          alu_w_d   = aluOut_m;
          rdata_w_d = '0;
          m2r_w_d   = valid_m & memToReg_m;
          halt_w_d  = valid_m & halt_m;
          err_w_d   = misaligned;
        end
      end

      S_REQ: begin
        // Memory is busy; keep offering the captured request
        mem_en_c = 1'b1;
        stall_c  = 1'b1;
        if (!mem.mem_stall) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem.mem_done) begin
          // Completion beats a timeout that falls in the same cycle
          valid_w_d = 1'b1;
          alu_w_d   = req_addr_q;
          rdata_w_d = req_wr_q ? '0 : mem.mem_rdata;
          m2r_w_d   = req_m2r_q;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          // Give up: release the pipe and hand WB an error result
          valid_w_d = 1'b1;
          err_w_d   = 1'b1;
          alu_w_d   = req_addr_q;
          rdata_w_d = '0;
          m2r_w_d   = req_m2r_q;
          state_d   = S_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef MEM_STALL_CNT_EN
  // Saturating count of frozen cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end
`endif

  // All controller and MEM/WB state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_m2r_q   <= 1'b0;
      valid_w_q   <= 1'b0;
      alu_w_q     <= '0;
      rdata_w_q   <= '0;
      m2r_w_q     <= 1'b0;
      halt_w_q    <= 1'b0;
      err_w_q     <= 1'b0;
`ifdef MEM_STALL_CNT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_m2r_q   <= req_m2r_d;
      valid_w_q   <= valid_w_d;
      alu_w_q     <= alu_w_d;
      rdata_w_q   <= rdata_w_d;
      m2r_w_q     <= m2r_w_d;
      halt_w_q    <= halt_w_d;
      err_w_q     <= err_w_d;
`ifdef MEM_STALL_CNT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  // Reset gates the combinational request so it drops without a clock edge
  assign mem.mem_en    = mem_en_c & rst;
  assign mem.mem_wr    = mem_wr_c;
  assign mem.mem_addr  = mem_addr_c;
  assign mem.mem_wdata = mem_wdata_c;
  assign stall_m       = stall_c & rst;

  assign valid_w    = valid_w_q;
  assign aluOut_w   = alu_w_q;
  assign readData_w = rdata_w_q;
  assign memToReg_w = m2r_w_q;
  assign halt_w     = halt_w_q;
  assign err_w      = err_w_q;
  assign state_dbg  = state_q;

`ifdef MEM_STALL_CNT_EN
  assign stallCycles = stall_cnt_q;
`endif

endmodule

// File: doc/memory_stage_ctrl.md
Name: memory_stage_ctrl

Overview:
Memory-stage controller that consumes the EX/MEM pipeline latch outputs (the read side of that latch) and drives the stalling data-memory handshake. It presents a freeze signal back to the front of the pipeline while an access is outstanding. Results are delivered to the WB stage through an internal MEM/WB register with a valid/bubble bit. Sits between the EX/MEM latch and the writeback stage of the 5-stage pipeline.

Parameters:
DATA_WIDTH, 16, width of address, data and ALU result.
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before an access is aborted with error.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
valid_m  input  1  EX/MEM slot holds a real instruction
memRead_m  input  1  load
memWrite_m  input  1  store
memToReg_m  input  1  WB selects read data
halt_m  input  1  halt instruction
aluOut_m  input  DATA_WIDTH  effective address / ALU result
read2Data_m  input  DATA_WIDTH  store data
mem_en  output  1  memory request
mem_wr  output  1  1 = write, 0 = read
mem_addr  output  DATA_WIDTH  request address
mem_wdata  output  DATA_WIDTH  request write data
mem_stall  input  1  memory cannot accept a request this cycle
mem_done  input  1  access complete; mem_rdata valid
mem_rdata  input  DATA_WIDTH  read data
stall_m  output  1  freeze EX/MEM and all earlier stages
valid_w  output  1  MEM/WB slot valid
aluOut_w  output  DATA_WIDTH  registered ALU result
readData_w  output  DATA_WIDTH  registered load data
memToReg_w  output  1  registered
halt_w  output  1  registered
err_w  output  1  misaligned access or timeout

Behaviour:
- Reset is asynchronous and active-low on rst: state=IDLE, all registered outputs 0, timeout counter 0.
- memop = valid_m & (memRead_m | memWrite_m) & ~halt_m & ~aluOut_m[0].
- misaligned = valid_m & (memRead_m | memWrite_m) & aluOut_m[0]:
  - No request is issued.
  - Passes in one cycle with err_w=1 and valid_w=1.
- Non-memory or halt instruction: no request, no stall; MEM/WB captures it on the next edge (latency 1).
- State machine IDLE / REQ / WAIT:
  - IDLE:
    - memop: mem_en=1 combinationally, with mem_wr=memWrite_m, mem_addr=aluOut_m, mem_wdata=read2Data_m; stall_m=1.
    - If mem_stall=0 the request is accepted and the next state is WAIT; otherwise the next state is REQ.
  - REQ: mem_en and request fields held; stall_m=1; next state is WAIT on the first cycle with mem_stall=0.
  - WAIT:
    - mem_en=0.
    - stall_m = ~mem_done.
    - On mem_done: readData_w<=mem_rdata (loads only; stores write 0), valid_w<=1, next state IDLE. EX/MEM advances on the same edge.
- mem_done outside WAIT is ignored.
- While stall_m=1, MEM/WB is loaded with a bubble (valid_w=0, err_w=0, halt_w=0) so WB never writes twice.
- Timeout:
  - The counter clears on WAIT entry and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without mem_done: abort to IDLE, err_w=1, valid_w=1, stall_m deasserted that cycle.
- mem_done and timeout in the same cycle: mem_done wins, err_w=0.
- Reset mid-access: immediate return to IDLE, mem_en=0, outstanding access forgotten.

Optional Feature:
MEM_STALL_CNT_EN:
- Defined: adds output stallCycles (16 bits), which counts cycles with stall_m=1. It saturates at 0xFFFF and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- ALU op, valid_m=1, aluOut_m=0x1234, no memop -> next cycle valid_w=1, aluOut_w=0x1234, stall_m never 1, mem_en never 1.
- Load addr 0x0040, mem_stall=0, mem_done 3 cycles after accept with rdata 0xBEEF -> stall_m=1 for 4 cycles, readData_w=0xBEEF with valid_w=1 exactly once, bubbles in between.
- Store addr 0x0010 data 0x00AA, mem_stall=1 for 2 cycles -> mem_en held 3 cycles with stable addr/data, then WAIT, single valid_w on mem_done.
- Load addr 0x0041 (odd) -> no mem_en, next cycle valid_w=1, err_w=1.
- Load with mem_done never asserted -> after 64 WAIT cycles err_w=1, valid_w=1, state back to IDLE; with MEM_STALL_CNT_EN defined, stallCycles=65.
- rst driven to 0 asynchronously during WAIT -> mem_en, stall_m, valid_w go to 0 without a clock edge; the next load proceeds normally.
